// File: rtl/credit_tx_mpi.sv
// Transmit side of the valid/yummy credit link: buffers upstream flits in a
// local FIFO and forwards one flit per available credit toward the receiver.
module credit_tx_mpi #(
    parameter int DATA_W     = 64,
    parameter int CREDITS    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        in_valid_i,
    input  logic [DATA_W-1:0]           in_data_i,
    output logic                        in_ready_o,
    output logic                        valid_o,
    output logic [DATA_W-1:0]           data_o,
    input  logic                        yummy_i,
    output logic [3:0]                  credits_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic [1:0]                  state_o,
    output logic                        credit_err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0]    CRED_MAX = 4'(CREDITS);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [3:0]        credits_q, credits_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    state_e            state_q, state_d;

    logic push_s;
    logic send_s;

    // Ready never looks at a same-cycle pop, so a full FIFO stays not-ready.
    assign in_ready_o = (count_q != DEPTH_C);
    assign push_s     = in_valid_i && in_ready_o;
    assign send_s     = (count_q != {CW{1'b0}}) && (credits_q != 4'd0);

    // Flit storage; only occupied entries are ever read, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    // FIFO pointer, occupancy and output-flit next-state logic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = 1'b0;
        data_d   = data_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (send_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            valid_d  = 1'b1;
            data_d   = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            valid_d  = 1'b0;
            data_d   = data_q;
        end
        if (push_s && !send_s) begin
            count_d = count_q + CW'(1);
        end else if (!push_s && send_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Credit counter: spend on send, restore on yummy, saturate and flag overflow.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (send_s && !yummy_i) begin
            credits_d = credits_q - 4'd1;
        end else if (!send_s && yummy_i) begin
            if (credits_q == CRED_MAX) begin
                credits_d = credits_q;
                err_d     = 1'b1;
            end else begin
                credits_d = credits_q + 4'd1;
            end
        end else begin
            credits_d = credits_q;
        end
    end

    // Observational state, derived from next-cycle occupancy and credits.
    always_comb begin
        state_d = state_q;
        if (count_d == {CW{1'b0}}) begin
            state_d = ST_IDLE;
        end else if (credits_d != 4'd0) begin
            state_d = ST_SEND;
        end else begin
            state_d = ST_STALL;
        end
    end

    // State register for the FSM.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and accounting registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {CW{1'b0}};
            credits_q <= CRED_MAX;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            credits_q <= credits_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
        end
    end

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign credits_o    = credits_q;
    assign fifo_count_o = count_q;
    assign state_o      = state_q;
    assign credit_err_o = err_q;

endmodule

// File: tb/tb_credit_tx_mpi.sv
// Directed bench for credit_tx_mpi: reset, single flit, credit stall,
// FIFO full, credit saturation and asynchronous reset mid-stall.
module tb_credit_tx_mpi;

    logic        clk_i;
    logic        rstn_i;
    logic        in_valid_i;
    logic [63:0] in_data_i;
    logic        in_ready_o;
    logic        valid_o;
    logic [63:0] data_o;
    logic        yummy_i;
    logic [3:0]  credits_o;
    logic [3:0]  fifo_count_o;
    logic [1:0]  state_o;
    logic        credit_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    credit_tx_mpi #(.DATA_W(64), .CREDITS(4), .FIFO_DEPTH(8)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .yummy_i      (yummy_i),
        .credits_o    (credits_o),
        .fifo_count_o (fifo_count_o),
        .state_o      (state_o),
        .credit_err_o (credit_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"},   64'(valid_o),      64'd0);
        check({tag, "_data"},    data_o,            64'd0);
        check({tag, "_credits"}, 64'(credits_o),    64'd4);
        check({tag, "_count"},   64'(fifo_count_o), 64'd0);
        check({tag, "_state"},   64'(state_o),      64'd0);
        check({tag, "_err"},     64'(credit_err_o), 64'd0);
        check({tag, "_ready"},   64'(in_ready_o),   64'd1);
    endtask

    initial begin
        rstn_i     = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = 64'd0;
        yummy_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_vals("in_reset");
        rstn_i = 1'b1;
        repeat (5) tick();
        check_reset_vals("idle");

        // Single flit: visible exactly one cycle after its push.
        in_valid_i = 1'b1;
        in_data_i  = 64'hA5A5_0000_0000_0001;
        tick();
        in_valid_i = 1'b0;
        check("single_n_valid", 64'(valid_o), 64'd0);
        check("single_n_count", 64'(fifo_count_o), 64'd1);
        check("single_n_state", 64'(state_o), 64'd1);
        tick();
        check("single_n1_valid", 64'(valid_o), 64'd1);
        check("single_n1_data", data_o, 64'hA5A5_0000_0000_0001);
        check("single_n1_credits", 64'(credits_o), 64'd3);
        check("single_n1_count", 64'(fifo_count_o), 64'd0);
        check("single_n1_state", 64'(state_o), 64'd0);
        tick();
        check("single_n2_valid", 64'(valid_o), 64'd0);
        check("single_n2_data_hold", data_o, 64'hA5A5_0000_0000_0001);

        yummy_i = 1'b1;
        tick();
        yummy_i = 1'b0;
        check("restore_credits", 64'(credits_o), 64'd4);

        // Six back-to-back flits with four credits.
        for (int i = 1; i <= 6; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 64'hC000_0000_0000_0000 | 64'(i);
            tick();
            if (i >= 2 && i <= 5) begin
                check("burst_valid", 64'(valid_o), 64'd1);
                check("burst_data", data_o, 64'hC000_0000_0000_0000 | 64'(i - 1));
            end else if (i == 6) begin
                check("burst_stop_valid", 64'(valid_o), 64'd0);
            end
        end
        in_valid_i = 1'b0;
        check("stall_credits", 64'(credits_o), 64'd0);
        check("stall_count", 64'(fifo_count_o), 64'd2);
        check("stall_state", 64'(state_o), 64'd2);

        for (int k = 5; k <= 6; k++) begin
            yummy_i = 1'b1;
            tick();
            yummy_i = 1'b0;
            check("yum_wait_valid", 64'(valid_o), 64'd0);
            check("yum_state_send", 64'(state_o), 64'd1);
            check("yum_credits1", 64'(credits_o), 64'd1);
            tick();
            check("yum_send_valid", 64'(valid_o), 64'd1);
            check("yum_send_data", data_o, 64'hC000_0000_0000_0000 | 64'(k));
            check("yum_send_credits", 64'(credits_o), 64'd0);
        end
        check("drained_count", 64'(fifo_count_o), 64'd0);
        check("drained_state", 64'(state_o), 64'd0);

        // Twelve pushes with no credits: only eight are accepted.
        for (int i = 1; i <= 12; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 64'hD000_0000_0000_0000 | 64'(i);
            tick();
            check("fill_count", 64'(fifo_count_o), 64'((i < 8) ? i : 8));
            check("fill_ready", 64'(in_ready_o), 64'((i < 8) ? 1 : 0));
            check("fill_valid", 64'(valid_o), 64'd0);
        end
        in_valid_i = 1'b0;
        yummy_i    = 1'b1;
        tick();
        yummy_i = 1'b0;
        check("full_yum_credits", 64'(credits_o), 64'd1);
        check("full_yum_count", 64'(fifo_count_o), 64'd8);
        check("full_yum_ready", 64'(in_ready_o), 64'd0);
        tick();
        check("full_send_valid", 64'(valid_o), 64'd1);
        check("full_send_data", data_o, 64'hD000_0000_0000_0001);
        check("full_send_count", 64'(fifo_count_o), 64'd7);
        check("full_send_ready", 64'(in_ready_o), 64'd1);
        check("full_send_credits", 64'(credits_o), 64'd0);

        // Drain with yummy held high: send and yummy cancel each cycle.
        yummy_i = 1'b1;
        tick();
        check("drain_credit_up", 64'(credits_o), 64'd1);
        check("drain_first_valid", 64'(valid_o), 64'd0);
        for (int k = 2; k <= 8; k++) begin
            tick();
            check("drain_valid", 64'(valid_o), 64'd1);
            check("drain_data", data_o, 64'hD000_0000_0000_0000 | 64'(k));
            check("drain_credits", 64'(credits_o), 64'd1);
        end
        check("drain_count", 64'(fifo_count_o), 64'd0);
        tick();
        yummy_i = 1'b0;
        check("two_credits", 64'(credits_o), 64'd2);
        check("two_state", 64'(state_o), 64'd0);
        check("two_valid", 64'(valid_o), 64'd0);

        // Send and yummy coincide at two credits.
        in_valid_i = 1'b1;
        in_data_i  = 64'hE000_0000_0000_0001;
        tick();
        in_valid_i = 1'b0;
        check("sy_pre_credits", 64'(credits_o), 64'd2);
        check("sy_pre_count", 64'(fifo_count_o), 64'd1);
        yummy_i = 1'b1;
        tick();
        yummy_i = 1'b0;
        check("sy_valid", 64'(valid_o), 64'd1);
        check("sy_data", data_o, 64'hE000_0000_0000_0001);
        check("sy_credits", 64'(credits_o), 64'd2);
        check("sy_count", 64'(fifo_count_o), 64'd0);

        // Saturation at full credits sets the sticky error.
        yummy_i = 1'b1;
        tick();
        tick();
        yummy_i = 1'b0;
        check("sat_pre_credits", 64'(credits_o), 64'd4);
        check("sat_pre_err", 64'(credit_err_o), 64'd0);
        yummy_i = 1'b1;
        tick();
        yummy_i = 1'b0;
        check("sat_credits", 64'(credits_o), 64'd4);
        check("sat_err", 64'(credit_err_o), 64'd1);
        repeat (3) tick();
        check("sat_err_sticky", 64'(credit_err_o), 64'd1);

        // Build a stall with five buffered flits, then reset asynchronously.
        for (int i = 1; i <= 9; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 64'hF000_0000_0000_0000 | 64'(i);
            tick();
        end
        in_valid_i = 1'b0;
        check("pre_rst_state", 64'(state_o), 64'd2);
        check("pre_rst_count", 64'(fifo_count_o), 64'd5);
        check("pre_rst_credits", 64'(credits_o), 64'd0);
        check("pre_rst_data", data_o, 64'hF000_0000_0000_0004);
        #2;
        rstn_i = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_valid", 64'(valid_o), 64'd0);
            check("post_rst_count", 64'(fifo_count_o), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/credit_tx_mpi.md
Name: credit_tx_mpi

Overview:
- Transmit end of the valid/yummy credit link used between fake nodes and the MPI bridge.
- Buffers locally produced 64-bit flits in a FIFO and drives valid_o/data_o toward a remote credit receiver.
- Spends one credit per flit sent; each returning yummy_i restores one credit.
- Sits between a local traffic source (valid/ready) and the MPI send path, as the counterpart of the receiver/yummy-return logic.

Parameters:
- DATA_W, 64, flit width.
- CREDITS, 4, receiver buffer depth = initial credit count; legal range 1..15.
- FIFO_DEPTH, 8, local flit buffer entries; power of 2, at least 2.

Ports:
- clk_i  input  1  clock.
- rstn_i  input  1  reset.
- in_valid_i  input  1  upstream flit valid.
- in_data_i  input  DATA_W  upstream flit.
- in_ready_o  output  1  FIFO can accept a flit.
- valid_o  output  1  flit valid toward receiver; single-cycle pulse per flit.
- data_o  output  DATA_W  flit toward receiver.
- yummy_i  input  1  one credit returned per high cycle.
- credits_o  output  4  current credit count.
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
- state_o  output  2  0=IDLE, 1=SEND, 2=STALL.
- credit_err_o  output  1  sticky: yummy received while credits == CREDITS.

Behaviour:
- Reset: reset rstn_i, asynchronous, active-low; clock clk_i. While rstn_i is low: valid_o=0, data_o=0, credits_o=CREDITS, fifo_count_o=0, state_o=IDLE, credit_err_o=0, FIFO pointers=0. Reset mid-operation discards all buffered flits and restores full credits.
- Push: push = in_valid_i && in_ready_o. in_ready_o = (fifo_count_o != FIFO_DEPTH), combinational. No full-with-pop bypass: a full FIFO is not ready even in a cycle where it pops.
- Pop/send: send = (fifo_count_o != 0) && (credits_o != 0). On send, the head is registered into data_o, valid_o=1 next cycle, and the FIFO pops. Otherwise valid_o=0 next cycle and data_o holds its last value.
- Latency: a flit pushed in cycle N appears on valid_o in cycle N+1 at the earliest. No bypass around the FIFO.
- Throughput: one flit per cycle while credits and data are available.
- FIFO accounting: push and pop in the same cycle leave fifo_count_o unchanged. Pointers wrap modulo FIFO_DEPTH.
- Credit update:
  - next credits = credits - send + yummy_i.
  - send and yummy in the same cycle: count unchanged.
  - yummy_i with credits == CREDITS and no send: count saturates at CREDITS and credit_err_o sets. It stays set until reset.
  - credits never underflows; send is gated by credits != 0.
- Remote side assumption: the receiver returns at most one yummy per consumed flit. No flit is ever sent without a credit.
- FSM (registered, evaluated from next-cycle fifo count and credits):
  - IDLE: FIFO empty.
  - SEND: FIFO non-empty and credits > 0.
  - STALL: FIFO non-empty and credits == 0.
  - Transitions:
    - IDLE->SEND on push with credits > 0.
    - IDLE->STALL on push with credits == 0.
    - SEND->STALL when the last credit is spent and data remains.
    - STALL->SEND on yummy_i.
    - SEND->IDLE when the last flit is sent and no push occurs.
  - state_o is observational; send is derived directly from count and credits.
- Widths: credits register is 4 bits. The count register is $clog2(FIFO_DEPTH)+1 bits so that FIFO_DEPTH itself is representable.
- No X propagation: data_o drives only FIFO contents or reset value.

Test Plan:
- Reset then idle 5 cycles -> valid_o=0, data_o=0, credits_o=4, fifo_count_o=0, in_ready_o=1, state_o=0.
- Push a single flit 0xA5A5_0000_0000_0001 at cycle N, yummy_i tied 0 -> valid_o=1 with that data at N+1 only; credits_o=3; state_o returns to IDLE.
- Push 6 flits back-to-back, no yummy -> flits 1-4 sent on consecutive cycles; credits_o=0; state_o=STALL; fifo_count_o=2. Pulse yummy_i twice -> remaining 2 flits sent in order, one cycle after each yummy; credits_o=0.
- Fill the FIFO with 12 pushes while credits=0 (after the stall above) -> in_ready_o=0 at fifo_count_o=8; flits 9-12 held off. One yummy -> one send, then in_ready_o=1.
- With credits_o=2, assert send and yummy_i in the same cycle -> credits_o stays 2. With credits_o=4 and an empty FIFO, pulse yummy_i -> credits_o=4 and credit_err_o=1, which stays set.
- Assert rstn_i low asynchronously mid-STALL with 5 flits buffered -> outputs return to reset values immediately; after release no stale flit appears on valid_o.
